// File: rtl/bridge_pkg.sv
// Shared types, constants and the nibble-to-ASCII helper for the host bridge transmit path.
package bridge_pkg;

    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] DEFAULT_PREAMBLE = 8'h44;  // "D"

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } bridge_tx_state_t;

    // Uppercase hex digit: 0-9 -> "0".."9", 10-15 -> "A".."F".
    function automatic logic [7:0] to_ascii_hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h41 + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/bridge_tx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Occupancy follows the net effect of the accepted push and pop.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count carries the extra full bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bridge_tx_fifo.sv
// Queues bus read responses and serialises each as preamble, hex digits and a line ending toward the UART.
module bridge_tx_fifo
    import bridge_pkg::*;
#(
    parameter int         DATA_WIDTH = 16,
    parameter int         DEPTH      = 8,
    parameter logic [7:0] PREAMBLE   = DEFAULT_PREAMBLE,
    parameter int         LINE_END   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    rw_i,
    input  logic                    valid_i,
    output logic [7:0]              data_o,
    output logic                    start_o,
    input  logic                    done_i,
    output logic [$clog2(DEPTH):0]  fifo_count_o,
    output logic                    overflow_o,
    input  logic                    clear_i
);

    localparam int ND = DATA_WIDTH / 4;
    localparam int NC = 1 + ND + ((LINE_END != 0) ? 1 : 2);
    localparam int IW = $clog2(NC);
    localparam logic [IW-1:0] LAST_IDX = IW'(NC - 1);

    bridge_tx_state_t      state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] msg_buf_q, msg_buf_d;
    logic                  overflow_q, overflow_d;

    logic                  push, pop, drop;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] shifted;

    assign push = valid_i && !rw_i;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (data_i),
        .dout  (fifo_dout),
        .count (fifo_count_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Character presented for the current state and index; digits are taken MSB nibble first.
    always_comb begin
        start_o = 1'b0;
        data_o  = 8'h00;
        shifted = msg_buf_q >> (4 * (ND - int'(idx_q)));
        if (state_q == SEND) begin
            start_o = 1'b1;
            if (idx_q == '0) begin
                data_o = PREAMBLE;
            end else if (idx_q <= IW'(ND)) begin
                data_o = to_ascii_hex(shifted[3:0]);
            end else if (LINE_END != 0 || idx_q == LAST_IDX) begin
                data_o = ASCII_LF;
            end else begin
                data_o = ASCII_CR;
            end
        end
    end

    // Serialiser next state: a finished message chains straight into the next queued one.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        msg_buf_d = msg_buf_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    msg_buf_d = fifo_dout;
                    idx_d     = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (done_i) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                    end else if (!fifo_empty) begin
                        pop       = 1'b1;
                        msg_buf_d = fifo_dout;
                        idx_d     = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A response is lost only when the FIFO is full and nothing leaves it this cycle; clear wins.
    always_comb begin
        drop       = push && fifo_full && !pop;
        overflow_d = clear_i ? 1'b0 : (overflow_q || drop);
    end

    assign overflow_o = overflow_q;

    // Serialiser and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            msg_buf_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            msg_buf_q  <= msg_buf_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_bridge_tx_fifo.sv
// Three configurations driven by shared stimulus, each checked every cycle against a queue-based model.
module tb_bridge_tx_fifo;

    logic        clk = 1'b0;
    logic        rst, rw, valid, done, clear;
    logic [23:0] data;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;
    string       crlf, lf;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Message character from the message rules, using plain arithmetic.
    function automatic logic [7:0] msg_char(input logic [63:0] w, input int pos, input int nd, input int le);
        logic [3:0] nib;
        if (pos == 0) return 8'h44;
        if (pos <= nd) begin
            nib = 4'((w >> (4 * (nd - pos))) & 64'hF);
            return (nib < 10) ? 8'h30 + 8'(nib) : 8'h37 + 8'(nib);
        end
        if (le != 0) return 8'h0A;
        return (pos == nd + 1) ? 8'h0D : 8'h0A;
    endfunction

    function automatic string build_msg(input logic [63:0] w, input int nd, input int le);
        string s = "";
        for (int p = 0; p < 1 + nd + ((le != 0) ? 1 : 2); p++)
            s = $sformatf("%s%c", s, msg_char(w, p, nd, le));
        return s;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int DW = (g == 2) ? 24 : 16;
        localparam int DP = (g == 1) ? 4 : 8;
        localparam int LE = (g == 2) ? 1 : 0;
        localparam int ND = DW / 4;
        localparam int NC = 1 + ND + ((LE != 0) ? 1 : 2);

        logic [7:0]           data_o;
        logic                 start_o, overflow_o;
        logic [$clog2(DP):0]  count_o;

        bridge_tx_fifo #(
            .DATA_WIDTH (DW),
            .DEPTH      (DP),
            .PREAMBLE   ("D"),
            .LINE_END   (LE)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .data_i       (data[DW-1:0]),
            .rw_i         (rw),
            .valid_i      (valid),
            .data_o       (data_o),
            .start_o      (start_o),
            .done_i       (done),
            .fifo_count_o (count_o),
            .overflow_o   (overflow_o),
            .clear_i      (clear)
        );

        logic [DW-1:0] mq[$];
        logic [DW-1:0] cur = '0;
        bit            busy = 1'b0;
        bit            ovf = 1'b0;
        int            pos = 0;
        string         tx_str = "";

        always @(negedge clk) begin
            bit accept, last, do_pop, full, push, drop;
            if (chk_en) begin
                check($sformatf("c%0d_start", g), start_o, busy);
                check($sformatf("c%0d_data", g), data_o, busy ? msg_char(cur, pos, ND, LE) : 8'h00);
                check($sformatf("c%0d_count", g), count_o, mq.size());
                check($sformatf("c%0d_ovf", g), overflow_o, ovf);
            end
            if (start_o === 1'b1 && done) tx_str = $sformatf("%s%c", tx_str, data_o);
            if (rst) begin
                mq.delete();
                busy = 1'b0; pos = 0; ovf = 1'b0; cur = '0;
            end else begin
                accept = busy && done;
                last   = accept && (pos == NC - 1);
                do_pop = (mq.size() > 0) && (!busy || last);
                full   = (mq.size() == DP);
                push   = valid && !rw;
                drop   = push && full && !do_pop;
                if (accept && !last) pos++;
                else if (do_pop) begin cur = mq.pop_front(); busy = 1'b1; pos = 0; end
                else if (last) begin busy = 1'b0; pos = 0; end
                if (push && !drop) mq.push_back(data[DW-1:0]);
                ovf = clear ? 1'b0 : (ovf || drop);
            end
        end

        task automatic compare_log(input string tag, input string exp);
            check($sformatf("c%0d_%s_len", g, tag), tx_str.len(), exp.len());
            for (int i = 0; i < exp.len() && i < tx_str.len(); i++)
                check($sformatf("c%0d_%s_ch%0d", g, tag, i), tx_str[i], exp[i]);
            tx_str = "";
        endtask

        task automatic clear_log();
            tx_str = "";
        endtask
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read(input logic [23:0] d);
        valid = 1'b1; rw = 1'b0; data = d;
        tick();
        valid = 1'b0;
    endtask

    function automatic bit all_idle();
        return !g_cfg[0].start_o && g_cfg[0].count_o == 0 &&
               !g_cfg[1].start_o && g_cfg[1].count_o == 0 &&
               !g_cfg[2].start_o && g_cfg[2].count_o == 0;
    endfunction

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (!all_idle() && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", all_idle(), 1'b1);
        tick();
    endtask

    initial begin
        logic [23:0] w[6];
        string       s0, s1, s2;
        crlf = $sformatf("%c%c", 8'h0D, 8'h0A);
        lf   = $sformatf("%c", 8'h0A);
        rst = 1'b1; valid = 1'b0; rw = 1'b0; data = '0; done = 1'b1; clear = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_start", g_cfg[0].start_o, 1'b0);
        check("reset_count", g_cfg[0].count_o, 0);
        tick();

        // Single response and its two-cycle latency.
        read(24'h00BEEF);
        @(negedge clk);
        check("t1_count", g_cfg[0].count_o, 1);
        check("t1_start_lo", g_cfg[0].start_o, 1'b0);
        tick();
        @(negedge clk);
        check("t1_start_hi", g_cfg[0].start_o, 1'b1);
        check("t1_preamble", g_cfg[0].data_o, 8'h44);
        wait_idle(100);
        g_cfg[0].compare_log("t1", {"DBEEF", crlf});
        g_cfg[2].compare_log("t1", {"D00BEEF", lf});
        g_cfg[1].clear_log();
        check("t1_ovf", g_cfg[0].overflow_o, 1'b0);

        // A write is ignored.
        valid = 1'b1; rw = 1'b1; data = 24'h001234;
        tick();
        valid = 1'b0; rw = 1'b0;
        @(negedge clk);
        check("t2_count", g_cfg[0].count_o, 0);
        check("t2_start", g_cfg[0].start_o, 1'b0);
        tick();

        // Back-to-back responses.
        read(24'h000001); read(24'h0000A0); read(24'h00FFFF);
        wait_idle(200);
        g_cfg[0].compare_log("t3", {"D0001", crlf, "D00A0", crlf, "DFFFF", crlf});
        g_cfg[2].compare_log("t3", {"D000001", lf, "D0000A0", lf, "D00FFFF", lf});
        g_cfg[1].clear_log();

        // Overflow with the UART stalled.
        done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w[i] = 24'($urandom_range(0, 24'hFFFFFF));
            read(w[i]);
        end
        @(negedge clk);
        check("t4_count_d4", g_cfg[1].count_o, 4);
        check("t4_ovf_d4", g_cfg[1].overflow_o, 1'b1);
        check("t4_count_d8", g_cfg[0].count_o, 5);
        check("t4_ovf_d8", g_cfg[0].overflow_o, 1'b0);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        check("t4_ovf_clr", g_cfg[1].overflow_o, 1'b0);
        tick();
        done = 1'b1;
        wait_idle(400);
        s0 = ""; s1 = ""; s2 = "";
        for (int i = 0; i < 6; i++) begin
            s0 = {s0, build_msg({48'h0, w[i][15:0]}, 4, 0)};
            if (i < 5) s1 = {s1, build_msg({48'h0, w[i][15:0]}, 4, 0)};
            s2 = {s2, build_msg({40'h0, w[i]}, 6, 1)};
        end
        g_cfg[0].compare_log("t4", s0);
        g_cfg[1].compare_log("t4", s1);
        g_cfg[2].compare_log("t4", s2);

        // Narrow line ending with a wide word.
        read(24'h00A1F0);
        wait_idle(100);
        g_cfg[2].compare_log("t5", {"D00A1F0", lf});
        g_cfg[0].compare_log("t5", {"DA1F0", crlf});
        g_cfg[1].clear_log();

        // Reset in the middle of a message.
        read(24'h001111); read(24'h002222); read(24'h003333);
        tick(); tick();
        @(negedge clk);
        check("t6_idx3_char", g_cfg[0].data_o, msg_char(64'h1111, 3, 4, 0));
        check("t6_queued", g_cfg[0].count_o, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_start", g_cfg[0].start_o, 1'b0);
        check("t6_count", g_cfg[0].count_o, 0);
        check("t6_ovf", g_cfg[0].overflow_o, 1'b0);
        for (int i = 0; i < 1; i++) begin
            g_cfg[0].clear_log(); g_cfg[1].clear_log(); g_cfg[2].clear_log();
        end
        tick();
        read(24'h00C0DE);
        wait_idle(100);
        g_cfg[0].compare_log("t6", {"DC0DE", crlf});
        g_cfg[2].compare_log("t6", {"D00C0DE", lf});

        // Randomised traffic; the per-cycle model does the checking.
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            valid = ($urandom_range(0, 9) < 6);
            rw    = ($urandom_range(0, 3) == 0);
            done  = ($urandom_range(0, 1) == 1);
            clear = ($urandom_range(0, 19) == 0);
            data  = 24'($urandom_range(0, 24'hFFFFFF));
            tick();
        end
        rst = 1'b0; valid = 1'b0; clear = 1'b0; done = 1'b1;
        wait_idle(500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
